bram_stream_seq: RTL and testbench

- Upstream command sequencer for bram_if_ctrl.
- Write job: accepts a valid/ready byte stream and issues one write command per byte at consecutive BRAM addresses.
- Read job: issues consecutive read commands, collects returned bytes (flagged by rdata_rdy) in a small credit-limited FIFO, and presents them as a valid/ready output stream with last marker.

---
 rtl/bram_seq_pkg.sv | 18 +
 rtl/bram_seq_fifo.sv | 54 +++++
 rtl/bram_stream_seq.sv | 158 +++++++++++++++
 tb/tb_bram_stream_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_seq_pkg.sv
// Shared types and default widths for the BRAM stream sequencer.
package bram_seq_pkg;

  localparam int BRAM_ADDR_W = 17;
  localparam int BRAM_DATA_W = 8;

  typedef logic [BRAM_ADDR_W-1:0] addr_t;
  typedef logic [BRAM_DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bram_seq_fifo.sv
// Read-return buffer: small synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module bram_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_seq.sv
// Command sequencer in front of bram_if_ctrl: write jobs turn an input byte
// stream into write commands; read jobs issue credit-limited read commands
// and stream the returned bytes out with a last marker.
// Optional macro BRAM_SEQ_BASE_EN adds a base_addr port latched on start;
// without it every job starts at address 0.
module bram_stream_seq
  import bram_seq_pkg::*;
#(
  parameter int ADDR_W     = BRAM_ADDR_W,
  parameter int DATA_W     = BRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic [ADDR_W-1:0] len,
`ifdef BRAM_SEQ_BASE_EN
  input  logic [ADDR_W-1:0] base_addr,
`endif
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              en,
  output logic              wr,
  output logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] wdata_in,
  input  logic              rdata_rdy,
  input  logic [DATA_W-1:0] rdata_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] pop_cnt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              accept;
  logic              issue;
  logic              ret;
  logic              pop;
  logic              credit_ok;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign s_ready   = (state == WR);
  assign cnt_nxt   = cnt + ADDR_W'(1);
  // A read may only go out if its byte is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);
  // Returns with nothing outstanding are strays (e.g. after a reset) and are dropped.
  assign ret       = rdata_rdy && (outstanding != '0);
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : fifo_head;
  assign pop       = !fifo_empty && m_ready;
  assign m_last    = !fifo_empty && (pop_cnt == len_q - ADDR_W'(1));

  bram_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ret && !fifo_full),
    .pop   (pop),
    .wdata (rdata_out),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus per-cycle write-accept and read-issue decisions.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr)      state_nxt = (len == '0) ? DONE : WR;
        else if (start_rd) state_nxt = (len == '0) ? DONE : RD;
      end
      WR: begin
        accept = s_valid;
        if (s_valid && (cnt_nxt == len_q)) state_nxt = DONE;
      end
      RD: begin
        issue = credit_ok && (cnt < len_q);
        if (issue && (cnt_nxt == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((outstanding == '0) && fifo_empty) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job registers, registered command outputs and read bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      len_q       <= '0;
      base_q      <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
      en          <= 1'b0;
      wr          <= 1'b0;
      addr_in     <= '0;
      wdata_in    <= '0;
    end else begin
      en <= 1'b0;
      if ((state == IDLE) && (start_wr || start_rd)) begin
        len_q   <= len;
`ifdef BRAM_SEQ_BASE_EN
        base_q  <= base_addr;
`else
        base_q  <= '0;
`endif
        cnt     <= '0;
        pop_cnt <= '0;
      end
      if (accept || issue) begin
        en      <= 1'b1;
        wr      <= accept;
        addr_in <= base_q + cnt;
        cnt     <= cnt_nxt;
      end
      if (accept) wdata_in <= s_data;
      case ({issue, ret})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (pop) pop_cnt <= pop_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_bram_stream_seq.sv
// Bench for bram_stream_seq: table of jobs plus hand-written reset and
// address-wrap sequences; a BRAM model answers reads two cycles later.
`timescale 1ns/1ps
module tb_bram_stream_seq;
  import bram_seq_pkg::*;

  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int FD    = 4;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_wr, start_rd;
  logic [AW-1:0] len;
`ifdef BRAM_SEQ_BASE_EN
  logic [AW-1:0] base_addr;
`endif
  logic          busy, done;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          en, wr;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata_in;
  logic          rdata_rdy = 1'b0;
  logic [DW-1:0] rdata_out = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_stream_seq #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_wr  (start_wr),
    .start_rd  (start_rd),
    .len       (len),
`ifdef BRAM_SEQ_BASE_EN
    .base_addr (base_addr),
`endif
    .busy      (busy),
    .done      (done),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .en        (en),
    .wr        (wr),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .rdata_rdy (rdata_rdy),
    .rdata_out (rdata_out)
  );

  typedef struct { logic wr; int addr; logic [7:0] wdata; } cmd_t;
  typedef struct { logic [7:0] data; logic last; } exp_t;
  typedef struct { logic [7:0] data; int due; } ret_t;
  typedef struct {
    bit sw; bit sr; int n; int base; logic [7:0] seed; bit gap; int hold;
    bit exp_wr; int exp_ncmd;
  } vec_t;

  cmd_t       cmd_q[$];
  exp_t       exp_q[$];
  ret_t       ret_q[$];
  logic [7:0] bram    [int];
  logic [7:0] exp_mem [int];

  int   cyc = 0;
  int   done_cnt, done_cyc, hs_cyc, pop_cyc, pop_n;
  bit   mv_seen;
  logic p_mv = 1'b0, p_mr = 1'b0;
  logic [7:0] p_md = '0;
  exp_t e;
  ret_t r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    return bram.exists(a) ? bram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] exp_byte(input int a);
    return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, output scoreboard and BRAM model, all evaluated mid-cycle.
  always @(negedge clk) begin
    if (m_valid) mv_seen = 1'b1;
    if (rst_n && p_mv && !p_mr) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, p_md);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", m_data, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e.data);
        chk("m_last", m_last, e.last);
      end
      pop_cyc = cyc;
      pop_n++;
    end
    if (s_valid && s_ready) hs_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (en) cmd_q.push_back('{wr, int'(addr_in), wdata_in});
    if (en && wr) bram[int'(addr_in)] = wdata_in;
    rdata_rdy = 1'b0;
    rdata_out = '0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      rdata_rdy = 1'b1;
      rdata_out = r.data;
    end
    if (en && !wr) ret_q.push_back('{model_rd(int'(addr_in)), cyc + 2});
    p_mv = m_valid && rst_n;
    p_mr = m_ready;
    p_md = m_data;
  end

  // Runs one job; entered and left at posedge+1.
  task automatic run_job(input vec_t v);
    int  k;
    bit  acc;
    cmd_q.delete();
    done_cnt = 0; pop_n = 0; pop_cyc = -1; done_cyc = -1; hs_cyc = -1;
    if (!v.exp_wr)
      for (int i = 0; i < v.n; i++)
        exp_q.push_back('{exp_byte((v.base + i) & AMASK), (i == v.n - 1)});
    m_ready  = (v.hold == 0);
    start_wr = v.sw;
    start_rd = v.sr;
    len      = v.n[AW-1:0];
`ifdef BRAM_SEQ_BASE_EN
    base_addr = v.base[AW-1:0];
`endif
    @(posedge clk); #1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    if (v.exp_wr) begin
      for (int i = 0; i < v.n; i++) begin
        s_valid = 1'b1;
        s_data  = v.seed + i[7:0];
        k = 0;
        acc = 1'b0;
        while (!acc && k < 50) begin
          @(negedge clk); acc = s_ready;
          @(posedge clk); #1; k++;
        end
        chk("wr_accept", acc, 1);
        exp_mem[(v.base + i) & AMASK] = s_data;
        s_valid = 1'b0;
        if (v.gap) begin @(posedge clk); #1; end
      end
    end
    if (v.hold > 0) begin
      repeat (v.hold) begin @(posedge clk); #1; end
      chk("credit_limit", (cmd_q.size() <= FD), 1);
      chk("no_pop_held", pop_n, 0);
      m_ready = 1'b1;
    end
    k = 0;
    while (done_cnt == 0 && k < 400) begin @(posedge clk); #1; k++; end
    repeat (2) begin @(posedge clk); #1; end
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("n_cmds", cmd_q.size(), v.exp_ncmd);
    for (int i = 0; i < cmd_q.size() && i < v.exp_ncmd; i++) begin
      chk("cmd_wr", cmd_q[i].wr, v.exp_wr);
      chk("cmd_addr", cmd_q[i].addr, (v.base + i) & AMASK);
      if (v.exp_wr) chk("cmd_wdata", cmd_q[i].wdata, v.seed + i[7:0]);
    end
    if (v.exp_wr && v.n > 0) chk("done_lat", done_cyc, hs_cyc + 1);
    if (!v.exp_wr && v.n > 0) begin
      chk("pops", pop_n, v.n);
      chk("exp_drained", exp_q.size(), 0);
      chk("done_after_pop", (done_cyc > pop_cyc), 1);
    end
  endtask

  vec_t vt[7];
  vec_t vb;

  initial begin
    int k;
    // sw sr  n    base seed   gap hold exp_wr ncmd
    vt[0] = '{1, 0, 4,  0, 8'hA1, 1, 0,  1, 4};
    vt[1] = '{0, 1, 4,  0, 8'h00, 0, 0,  0, 4};
    vt[2] = '{1, 0, 0,  0, 8'h00, 0, 0,  1, 0};
    vt[3] = '{0, 1, 0,  0, 8'h00, 0, 0,  0, 0};
    vt[4] = '{1, 1, 2,  0, 8'hB1, 0, 0,  1, 2};
    vt[5] = '{0, 1, 4,  0, 8'h00, 0, 0,  0, 4};
    vt[6] = '{0, 1, 16, 0, 8'h00, 0, 50, 0, 16};

    rst_n = 1'b1; start_wr = 0; start_rd = 0; len = '0;
`ifdef BRAM_SEQ_BASE_EN
    base_addr = '0;
`endif
    s_valid = 0; s_data = '0; m_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", en, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr_in, 0);
    chk("rst_wdata", wdata_in, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_job(vt[i]);

`ifdef BRAM_SEQ_BASE_EN
    vb = '{1, 0, 4, 'h1FFFE, 8'hC1, 0, 0, 1, 4};
    run_job(vb);
    vb = '{0, 1, 4, 'h1FFFE, 8'h00, 0, 0, 0, 4};
    run_job(vb);
`endif

    // Reset in the middle of a read job.
    exp_q.delete(); cmd_q.delete();
    m_ready = 1'b0;
    len = AW'(8); start_rd = 1'b1;
`ifdef BRAM_SEQ_BASE_EN
    base_addr = '0;
`endif
    @(posedge clk); #1; start_rd = 1'b0;
    k = 0;
    while (cmd_q.size() < 3 && k < 50) begin @(posedge clk); #1; k++; end
    chk("mid_reads_seen", (cmd_q.size() >= 3), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_addr", addr_in, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    mv_seen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("stray_dropped", mv_seen, 0);
    chk("post_rst_busy", busy, 0);
    vb = '{0, 1, 2, 0, 8'h00, 0, 0, 0, 2};
    run_job(vb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
